// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, buffers up to DEPTH words while decode stalls.
// Optional macro FQ_BLANK_HALT_EN stops fetch on an all-zero ROM word until jump or reset.
module fetch_queue #(
  parameter int PC_W    = 5,
  parameter int INSTR_W = 18,
  parameter int DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall_d,
  input  logic                         jump_d,
  input  logic [PC_W-1:0]              jump_dest,
  output logic [PC_W-1:0]              rom_addr,
  input  logic [INSTR_W-1:0]           rom_data,
  output logic [PC_W-1:0]              pc_d,
  output logic [INSTR_W-1:0]           instr_d,
  output logic                         valid_d,
  output logic                         jump_flush_d,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         halted
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PC_W-1:0]    buf_pc_q    [DEPTH];
  logic [INSTR_W-1:0] buf_instr_q [DEPTH];
  logic [PC_W-1:0]    out_pc_q, out_pc_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic               out_valid_q, out_valid_d;
  logic               flush_q, flush_d;
  logic               halted_q, halted_d;
  logic               fetch_ok, enq, pop;

`ifdef FQ_BLANK_HALT_EN
  assign fetch_ok = !halted_q && (rom_data != '0);
`else
  assign fetch_ok = 1'b1;
`endif

  always_comb begin
    enq         = 1'b0;
    pop         = 1'b0;
    fetch_pc_d  = fetch_pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_valid_d = out_valid_q;
    flush_d     = flush_q;
    halted_d    = halted_q;
    if (jump_d) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      fetch_pc_d  = jump_dest;
      halted_d    = 1'b0;
      out_pc_d    = '0;
      out_instr_d = '0;
      out_valid_d = 1'b0;
      flush_d     = 1'b1;
    end else begin
`ifdef FQ_BLANK_HALT_EN
      halted_d = halted_q | (rom_data == '0);
`else
      halted_d = 1'b0;
`endif
      if (stall_d) begin
        enq = fetch_ok && (count_q < CNT_W'(DEPTH));
      end else begin
        flush_d = 1'b0;
        if (count_q != '0) begin
          // Buffered words always issue ahead of the ROM to keep program order.
          pop         = 1'b1;
          enq         = fetch_ok;
          out_pc_d    = buf_pc_q[head_q];
          out_instr_d = buf_instr_q[head_q];
          out_valid_d = 1'b1;
        end else if (fetch_ok) begin
          out_pc_d    = fetch_pc_q;
          out_instr_d = rom_data;
          out_valid_d = 1'b1;
          fetch_pc_d  = fetch_pc_q + PC_W'(1);
        end else begin
          out_pc_d    = '0;
          out_instr_d = '0;
          out_valid_d = 1'b0;
        end
      end
      if (enq) begin
        tail_d     = tail_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + PC_W'(1);
      end
      if (pop) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(enq) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q  <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      out_valid_q <= 1'b0;
      flush_q     <= 1'b1;
      halted_q    <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_valid_q <= out_valid_d;
      flush_q     <= flush_d;
      halted_q    <= halted_d;
    end
  end

  // Storage needs no reset; occupancy gates what is ever read.
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      buf_pc_q[tail_q]    <= fetch_pc_q;
      buf_instr_q[tail_q] <= rom_data;
    end
  end

  assign rom_addr     = fetch_pc_q;
  assign pc_d         = out_pc_q;
  assign instr_d      = out_instr_q;
  assign valid_d      = out_valid_q;
  assign jump_flush_d = flush_q;
  assign occupancy    = count_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, blank-word sequence, randomized run vs. queue model.
module tb_fetch_queue;
  localparam int PC_W = 5, INSTR_W = 18, DEPTH = 4;
`ifdef FQ_BLANK_HALT_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, stall_d, jump_d;
  logic [PC_W-1:0]    jump_dest, rom_addr, pc_d;
  logic [INSTR_W-1:0] rom_data, instr_d;
  logic               valid_d, jump_flush_d, halted;
  logic [2:0]         occupancy;
  logic [INSTR_W-1:0] rom [32];

  assign rom_data = rom[rom_addr];

  fetch_queue #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall_d(stall_d), .jump_d(jump_d), .jump_dest(jump_dest),
    .rom_addr(rom_addr), .rom_data(rom_data), .pc_d(pc_d), .instr_d(instr_d),
    .valid_d(valid_d), .jump_flush_d(jump_flush_d), .occupancy(occupancy), .halted(halted)
  );

  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic r, s, j; int dest;
    int pc; int instr; int v; int f; int occ; int addr;
  } vec_t;
  vec_t vt[$];

  typedef struct { int pc; logic [INSTR_W-1:0] w; } ent_t;
  ent_t mq[$];
  int m_pc, m_pcd; logic [INSTR_W-1:0] m_ins; bit m_v, m_f, m_halt;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic add(input logic r, s, j, input int dest, pc, instr, v, f, occ, addr);
    vec_t e;
    e.r = r; e.s = s; e.j = j; e.dest = dest;
    e.pc = pc; e.instr = instr; e.v = v; e.f = f; e.occ = occ; e.addr = addr;
    vt.push_back(e);
  endtask

  task automatic drive(input logic r, s, j, input int dest);
    reset = r; stall_d = s; jump_d = j; jump_dest = PC_W'(dest);
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input logic r, s, j, input int dest);
    logic [INSTR_W-1:0] w;
    bit ok;
    ent_t e;
    w  = rom[m_pc];
    ok = !m_halt && (!BLANK || w != '0);
    if (r) begin
      mq.delete(); m_pc = 0; m_pcd = 0; m_ins = '0; m_v = 0; m_f = 1; m_halt = 0;
    end else if (j) begin
      mq.delete(); m_pc = dest; m_pcd = 0; m_ins = '0; m_v = 0; m_f = 1; m_halt = 0;
    end else begin
      if (BLANK && w == '0) m_halt = 1;
      if (s) begin
        if (ok && mq.size() < DEPTH) begin
          e.pc = m_pc; e.w = w; mq.push_back(e); m_pc = (m_pc + 1) % 32;
        end
      end else begin
        m_f = 0;
        if (mq.size() > 0) begin
          e = mq.pop_front();
          m_pcd = e.pc; m_ins = e.w; m_v = 1;
          if (ok) begin
            e.pc = m_pc; e.w = w; mq.push_back(e); m_pc = (m_pc + 1) % 32;
          end
        end else if (ok) begin
          m_pcd = m_pc; m_ins = w; m_v = 1; m_pc = (m_pc + 1) % 32;
        end else begin
          m_pcd = 0; m_ins = '0; m_v = 0;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = INSTR_W'(18'h11 * (i + 1));
    reset = 1'b1; stall_d = 1'b0; jump_d = 1'b0; jump_dest = '0;

    //   r  s  j  dest | pc  instr  v  f  occ addr
    // straight-line bypass after reset
    add(1, 0, 0, 0,    0,  0,     0, 1, 0, 0);
    add(0, 0, 0, 0,    0,  'h11,  1, 0, 0, 1);
    add(0, 0, 0, 0,    1,  'h22,  1, 0, 0, 2);
    add(0, 0, 0, 0,    2,  'h33,  1, 0, 0, 3);
    add(0, 0, 0, 0,    3,  'h44,  1, 0, 0, 4);
    // six-cycle stall from pc 1, then back-to-back drain
    add(1, 0, 0, 0,    0,  0,     0, 1, 0, 0);
    add(0, 0, 0, 0,    0,  'h11,  1, 0, 0, 1);
    add(0, 1, 0, 0,    0,  'h11,  1, 0, 1, 2);
    add(0, 1, 0, 0,    0,  'h11,  1, 0, 2, 3);
    add(0, 1, 0, 0,    0,  'h11,  1, 0, 3, 4);
    add(0, 1, 0, 0,    0,  'h11,  1, 0, 4, 5);
    add(0, 1, 0, 0,    0,  'h11,  1, 0, 4, 5);
    add(0, 1, 0, 0,    0,  'h11,  1, 0, 4, 5);
    add(0, 0, 0, 0,    1,  'h22,  1, 0, 4, 6);
    add(0, 0, 0, 0,    2,  'h33,  1, 0, 4, 7);
    add(0, 0, 0, 0,    3,  'h44,  1, 0, 4, 8);
    add(0, 0, 0, 0,    4,  'h55,  1, 0, 4, 9);
    add(0, 0, 0, 0,    5,  'h66,  1, 0, 4, 10);
    // jump during stall with occupancy 3
    add(1, 0, 0, 0,    0,  0,     0, 1, 0, 0);
    add(0, 0, 0, 0,    0,  'h11,  1, 0, 0, 1);
    add(0, 1, 0, 0,    0,  'h11,  1, 0, 1, 2);
    add(0, 1, 0, 0,    0,  'h11,  1, 0, 2, 3);
    add(0, 1, 0, 0,    0,  'h11,  1, 0, 3, 4);
    add(0, 1, 1, 12,   0,  0,     0, 1, 0, 12);
    add(0, 0, 0, 0,    12, 'hDD,  1, 0, 0, 13);
    // PC wrap
    add(0, 0, 1, 30,   0,  0,     0, 1, 0, 30);
    add(0, 0, 0, 0,    30, 'h20F, 1, 0, 0, 31);
    add(0, 0, 0, 0,    31, 'h220, 1, 0, 0, 0);
    add(0, 0, 0, 0,    0,  'h11,  1, 0, 0, 1);
    add(0, 0, 0, 0,    1,  'h22,  1, 0, 0, 2);
    // reset mid-operation with occupancy 2, valid 1
    add(0, 1, 0, 0,    1,  'h22,  1, 0, 1, 3);
    add(0, 1, 0, 0,    1,  'h22,  1, 0, 2, 4);
    add(1, 0, 0, 0,    0,  0,     0, 1, 0, 0);
    // flush flag holds through a stall
    add(0, 1, 0, 0,    0,  0,     0, 1, 1, 1);
    add(0, 0, 0, 0,    0,  'h11,  1, 0, 1, 2);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].r, vt[i].s, vt[i].j, vt[i].dest);
      chk($sformatf("v%0d.pc", i),     32'(pc_d),         32'(vt[i].pc));
      chk($sformatf("v%0d.instr", i),  32'(instr_d),      32'(vt[i].instr));
      chk($sformatf("v%0d.valid", i),  32'(valid_d),      32'(vt[i].v));
      chk($sformatf("v%0d.flush", i),  32'(jump_flush_d), 32'(vt[i].f));
      chk($sformatf("v%0d.occ", i),    32'(occupancy),    32'(vt[i].occ));
      chk($sformatf("v%0d.addr", i),   32'(rom_addr),     32'(vt[i].addr));
      chk($sformatf("v%0d.halted", i), 32'(halted),       32'd0);
    end

    // blank word at address 2
    rom[2] = '0;
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("blk.pc0", 32'(pc_d), 32'd0);
    drive(0, 0, 0, 0);
    chk("blk.pc1", 32'(pc_d), 32'd1);
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0);
`ifdef FQ_BLANK_HALT_EN
      chk($sformatf("blk.bub%0d.valid", k),  32'(valid_d),  32'd0);
      chk($sformatf("blk.bub%0d.halted", k), 32'(halted),   32'd1);
      chk($sformatf("blk.bub%0d.addr", k),   32'(rom_addr), 32'd2);
`else
      chk($sformatf("blk.nop%0d.valid", k),  32'(valid_d),  32'd1);
      chk($sformatf("blk.nop%0d.pc", k),     32'(pc_d),     32'(2 + k));
      chk($sformatf("blk.nop%0d.halted", k), 32'(halted),   32'd0);
`endif
    end
    drive(0, 0, 1, 0);
    chk("blk.jmp.halted", 32'(halted),   32'd0);
    chk("blk.jmp.addr",   32'(rom_addr), 32'd0);
    chk("blk.jmp.flush",  32'(jump_flush_d), 32'd1);

    // randomized run against the queue model
    for (int i = 0; i < 32; i++)
      rom[i] = ($urandom_range(0, 7) == 0) ? '0 : INSTR_W'($urandom_range(1, 18'h3FFFF));
    model_step(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      logic r, s, j;
      int dest;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 99) < 45);
      j = ($urandom_range(0, 99) < 6);
      dest = $urandom_range(0, 31);
      model_step(r, s, j, dest);
      drive(r, s, j, dest);
      chk($sformatf("r%0d.addr", c),   32'(rom_addr),     32'(m_pc));
      chk($sformatf("r%0d.pc", c),     32'(pc_d),         32'(m_pcd));
      chk($sformatf("r%0d.instr", c),  32'(instr_d),      32'(m_ins));
      chk($sformatf("r%0d.valid", c),  32'(valid_d),      32'(m_v));
      chk($sformatf("r%0d.flush", c),  32'(jump_flush_d), 32'(m_f));
      chk($sformatf("r%0d.occ", c),    32'(occupancy),    32'(mq.size()));
      chk($sformatf("r%0d.halted", c), 32'(halted),       32'(m_halt));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
